// File: rtl/inst_fetch.sv
// Fetch stage: PC register, 2-entry fetch queue, redirect and fault handling; word addressed in cycle N is presented in N+1.
// Decode backpressure fills the queue, then the PC stalls; a fault freezes the PC until a redirect or reset.
module inst_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_raddr_o,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        id_ready_i,
   output logic        id_valid_o,
   output logic [31:0] id_inst_o,
   output logic [31:0] id_pc_o,
   output logic        id_fault_o
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {RUN, HALT} mode_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } entry_t;

   logic [31:0] pc_q, pc_d;
   mode_e       mode_q, mode_d;
   logic [1:0]  cnt_q, cnt_d;
   entry_t      head_q, head_d;
   entry_t      tail_q, tail_d;

   logic   has_head;
   logic   pc_fault;
   logic   deq;
   logic   enq;
   entry_t new_e;

   assign has_head = (cnt_q != 2'd0);
   assign pc_fault = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS));
   assign deq      = id_valid_o & id_ready_i;
   assign enq      = (mode_q == RUN) & ~redirect_i & ((cnt_q != 2'd2) | deq);
   assign new_e    = pc_fault ? '{pc: pc_q, inst: NOP, fault: 1'b1}
                              : '{pc: pc_q, inst: imem_rdata_i, fault: 1'b0};

   always_comb begin
      pc_d   = pc_q;
      mode_d = mode_q;
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      if (redirect_i) begin
         cnt_d  = 2'd0;
         pc_d   = redirect_pc_i;
         mode_d = RUN;
      end else begin
         case ({enq, deq})
            2'b10: begin
               if (cnt_q == 2'd0) head_d = new_e;
               else               tail_d = new_e;
               cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
               head_d = tail_q;
               cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
               // Count is unchanged; with two entries the tail shifts up so order is kept.
               if (cnt_q == 2'd1) begin
                  head_d = new_e;
               end else begin
                  head_d = tail_q;
                  tail_d = new_e;
               end
            end
            default: ;
         endcase
         if (enq) begin
            if (pc_fault) mode_d = HALT;
            else          pc_d   = pc_q + 32'd4;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         mode_q <= RUN;
         cnt_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         pc_q   <= pc_d;
         mode_q <= mode_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   assign imem_raddr_o = pc_q;
   assign id_valid_o   = has_head & ~redirect_i;
   assign id_inst_o    = has_head ? head_q.inst  : NOP;
   assign id_pc_o      = has_head ? head_q.pc    : 32'd0;
   assign id_fault_o   = has_head ? head_q.fault : 1'b0;

endmodule
